// File: rtl/mdu_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit_if
// Description : Operation/operand and result bundle for the multiply/divide
//               unit. The master modport issues operations and the slave
//               modport is the MDU.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_unit_if;
  logic [3:0]  MDUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  modport master (
    output MDUControl, A, B,
    input  Start, Busy, HI, LO, MDUOut
  );

  modport slave (
    input  MDUControl, A, B,
    output Start, Busy, HI, LO, MDUOut
  );
endinterface
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : E-stage multiply/divide unit with HI/LO registers. Results are
//               computed when the operation starts and committed to HI/LO
//               after a fixed Busy latency, so the pipeline sees a multi-cycle
//               unit.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] load_count;
  logic             last_cycle;
  logic             start;
  logic             busy;

  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_we;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;

  assign last_cycle = (counter <= CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> IDLE on the final count
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)      state_next = ST_RUN;
      ST_RUN:  if (last_cycle) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // Outputs: Busy follows the state, Start only when an arithmetic op meets an idle unit
  always_comb begin
    busy        = (state == ST_RUN);
    start       = (bus.MDUControl >= OP_MULT) && (bus.MDUControl <= OP_DIVU) && !busy;
    bus.Busy    = busy;
    bus.Start   = start;
    bus.HI      = hi_reg;
    bus.LO      = lo_reg;
    bus.MDUOut  = (bus.MDUControl == OP_MFHI) ? hi_reg :
                  (bus.MDUControl == OP_MFLO) ? lo_reg : 32'd0;
  end

  // Arithmetic results; divide-by-zero substitutes a divisor of 1 and suppresses the commit
  always_comb begin
    prod_s  = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prod_u  = {32'd0, bus.A} * {32'd0, bus.B};
    divisor = (bus.B == 32'd0) ? 32'd1 : bus.B;
    quot_s  = $signed(bus.A) / $signed(divisor);
    rem_s   = $signed(bus.A) % $signed(divisor);
    quot_u  = bus.A / divisor;
    rem_u   = bus.A % divisor;
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_we  = 1'b1;
    case (bus.MDUControl)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = rem_s; res_lo = quot_s; res_we = (bus.B != 32'd0); end
      OP_DIVU:  begin res_hi = rem_u; res_lo = quot_u; res_we = (bus.B != 32'd0); end
      default:  res_we = 1'b0;
    endcase
    load_count = ((bus.MDUControl == OP_DIV) || (bus.MDUControl == OP_DIVU))
                 ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  // Datapath: capture results at start, count down in RUN, commit on the last edge, mt* only when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
      hi_reg  <= 32'd0;
      lo_reg  <= 32'd0;
    end else if (start) begin
      counter <= load_count;
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_we <= res_we;
    end else if (state == ST_RUN) begin
      counter <= counter - CNT_W'(1);
      if (last_cycle && pend_we) begin
        hi_reg <= pend_hi;
        lo_reg <= pend_lo;
      end
    end else begin
      if (bus.MDUControl == OP_MTHI) hi_reg <= bus.A;
      if (bus.MDUControl == OP_MTLO) lo_reg <= bus.A;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_unit
// Description : Self-checking bench for mdu_unit. Directed operations push
//               expected Busy length and HI/LO into a scoreboard queue; a
//               monitor pops and compares when Busy drops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

  typedef struct {
    string       name;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  mdu_unit_if bus ();

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: measure each Busy run and compare the committed HI/LO once Busy falls
  bit prev_busy = 1'b0;
  int run_len   = 0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.Busy === 1'b1) begin
      run_len++;
    end else if (prev_busy) begin
      if (sb.size() == 0) begin
        check("unexpected_busy_run", 32'(run_len), 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_busy_len"}, 32'(run_len), 32'(e.cycles));
        check({e.name, "_hi"}, bus.HI, e.hi);
        check({e.name, "_lo"}, bus.LO, e.lo);
      end
      run_len = 0;
    end
    prev_busy = (bus.Busy === 1'b1);
  end

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.MDUControl = c;
    bus.A          = a;
    bus.B          = b;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({name, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name; e.cycles = cycles; e.hi = hi; e.lo = lo;
    sb.push_back(e);
    drive(c, a, b);
    @(negedge clk);
    check({name, "_start"}, 32'(bus.Start), 32'd1);
    drive(4'd0, 32'd0, 32'd0);
    wait_idle(name);
  endtask

  initial begin
    exp_t e;
    bit   drained;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.MDUControl = 4'd0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hi", bus.HI, 32'd0);
    check("reset_lo", bus.LO, 32'd0);
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_mduout", bus.MDUOut, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // signed multiply -2 * 3
    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    drive(4'd6, 32'd0, 32'd0);
    @(negedge clk);
    check("mflo_after_mult", bus.MDUOut, 32'hFFFF_FFFA);

    // unsigned multiply
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);

    // signed divide -7 / 2
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // preload HI/LO, then divide by zero leaves them intact
    drive(4'd7, 32'h11, 32'd0);
    drive(4'd8, 32'h22, 32'd0);
    @(negedge clk);
    check("mthi_preload", bus.HI, 32'h11);
    drive(4'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("mtlo_preload", bus.LO, 32'h22);
    run_op("divu_by_zero", 4'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22);

    // idle mthi
    drive(4'd7, 32'h1234, 32'd0);
    drive(4'd5, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi_hi", bus.HI, 32'h1234);
    check("mthi_no_busy", 32'(bus.Busy), 32'd0);
    check("mfhi_read", bus.MDUOut, 32'h1234);

    // unused opcode behaves as none
    drive(4'd9, 32'd5, 32'd5);
    @(negedge clk);
    check("op9_start", 32'(bus.Start), 32'd0);
    check("op9_mduout", bus.MDUOut, 32'd0);

    // mtlo and a second mult during Busy are ignored
    e.name = "mult_ignore"; e.cycles = 5; e.hi = 32'd0; e.lo = 32'd15;
    sb.push_back(e);
    drive(4'd1, 32'd3, 32'd5);
    @(negedge clk);
    check("mult_ignore_start", 32'(bus.Start), 32'd1);
    drive(4'd8, 32'h55, 32'd0);
    drive(4'd1, 32'd7, 32'd7);
    @(negedge clk);
    check("mtlo_during_busy", bus.LO, 32'h22);
    check("start_during_busy", 32'(bus.Start), 32'd0);
    drive(4'd0, 32'd0, 32'd0);
    wait_idle("mult_ignore");

    // reset in the 4th Busy cycle of a divide
    e.name = "div_abort"; e.cycles = 4; e.hi = 32'd0; e.lo = 32'd0;
    sb.push_back(e);
    drive(4'd3, 32'd100, 32'd7);
    @(negedge clk);
    check("div_abort_start", 32'(bus.Start), 32'd1);
    drive(4'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    repeat (15) @(negedge clk);
    check("abort_no_commit_hi", bus.HI, 32'd0);
    check("abort_no_commit_lo", bus.LO, 32'd0);

    // reset together with Start: reset wins
    drive(4'd1, 32'd2, 32'd3);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    bus.MDUControl = 4'd0;
    @(negedge clk);
    check("reset_beats_start", 32'(bus.Busy), 32'd0);
    repeat (8) @(negedge clk);
    check("reset_beats_start_lo", bus.LO, 32'd0);

    drained = (sb.size() == 0);
    check("scoreboard_drained", 32'(drained), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the 4-bit MDUControl code from the instruction decoder, plus the forwarded rs/rt operands.
- Holds the HI/LO registers.
- Models multi-cycle latency with a Busy handshake; the hazard unit uses Busy to stall later MDU instructions in D.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu.
- DIV_CYCLES, 10, number of Busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MDUControl  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; values 9–15 are treated as none.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- Start  output  1  combinational; high when MDUControl is 1–4 and Busy=0.
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDUOut  output  32  combinational: HI when MDUControl=5, LO when MDUControl=6, else 0.

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, Busy=0, counter=0, pending results cleared. Start and MDUOut follow their combinational definitions.
- States:
  - IDLE (Busy=0).
  - RUN (Busy=1, counter counts down).
- IDLE, Start=1:
  - Latch the op result at this edge into pendHI/pendLO:
    - mult: signed 64-bit product of A*B; {pendHI,pendLO} = product.
    - multu: unsigned 64-bit product.
    - div: pendLO = signed quotient (truncates toward zero); pendHI = remainder, sign of dividend.
    - divu: unsigned quotient and remainder.
  - Counter loads MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter reaches 0, commit HI<=pendHI and LO<=pendLO, then go to IDLE.
  - Busy is high for exactly N consecutive cycles, starting the cycle after Start.
- Divide by zero (B=0, op 3 or 4): still runs DIV_CYCLES with Busy high; HI/LO stay unchanged at commit.
- mthi/mtlo:
  - Only in IDLE: HI<=A or LO<=A at the edge; no Busy.
  - While Busy=1 they are ignored. The hazard unit guarantees none arrive; the bench checks the ignore.
- mult/multu/div/divu while Busy=1: ignored, Start=0, no restart.
- mfhi/mflo:
  - Combinational read of the current HI/LO registers.
  - During RUN this returns the old values (the stall unit prevents this in practice).
  - In the cycle of commit it returns the pre-commit value; the new value is visible the next cycle.
- Reset asserted during RUN: the in-flight op is discarded, Busy=0 next cycle, HI/LO=0.
- Reset together with Start: reset wins.
- No simultaneous HI/LO writers are possible: a commit occurs only in RUN, and mt* only takes effect in IDLE.

Test Plan:
- Reset, then MDUControl=1, A=0xFFFFFFFE (-2), B=3 for one cycle:
  - Start=1 in that cycle.
  - Busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - mflo returns 0xFFFFFFFA.
- MDUControl=2 (multu), A=0xFFFFFFFE, B=3 → after 5 Busy cycles HI=0x00000002, LO=0xFFFFFFFA.
- MDUControl=3 (div), A=-7 (0xFFFFFFF9), B=2:
  - Busy for 10 cycles.
  - LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- MDUControl=4 (divu), A=7, B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo:
  - Busy for 10 cycles.
  - HI/LO remain 0x11/0x22.
- mthi A=0x1234 while idle → HI=0x1234 next cycle, Busy stays 0. During Busy, present mtlo A=0x55 and mult:
  - LO is unaffected by the mtlo.
  - Start=0 for the mult.
  - Busy count is not restarted.
- Start a div, assert reset in the 4th Busy cycle → next cycle Busy=0, HI=LO=0, and no commit occurs afterwards.
